// File: rtl/stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_pkg                                                               |
// | Shared types and slice-placement helpers for the slice-stream packer     |
// | and unpacker, so both sides agree on where slice k lives in a word.      |
// | Optional build macro: STREAM_UNPACK_RIGHT_EN (right-stream placement).   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package stream_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Number of slices that make up one word.
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Bit offset of the least significant bit of slice k inside the word.
  // Left-stream reverses slice order (first beat lands in the low slice);
  // right-stream keeps order (first beat lands in the high slice).
  function automatic int slice_lo(input int k, input int slice, input int width);
`ifdef STREAM_UNPACK_RIGHT_EN
    return width - (k + 1) * slice;
`else
    return k * slice;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_slice_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_slice_cnt                                                         |
// | Fill counter for the slice unpacker: counts 0..NSLICE, clears on        |
// | i_clr or word retire, loads 1 when a retire and a new slice coincide.    |
// | Ports: clk, rst_n (async active-low), i_clr, i_inc, i_retire, i_load1,   |
// |        o_cnt (slices accepted into the current word).                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module stream_slice_cnt #(
  parameter int NSLICE = 8,
  localparam int CW = $clog2(NSLICE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic          i_retire,
  input  logic          i_load1,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  // Priority: clear wins over everything; a retire with a same-cycle slice
  // starts the next word at one; a plain retire returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= CW'(1);
    end else if (i_retire) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/stream_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stream_unpack                                                            |
// | Gathers NSLICE = WIDTH/SLICE slices of a left-streamed word (MSB slice   |
// | first), undoes the slice reordering and presents the word on a           |
// | valid/ready output. In HOLD the input is bypass-ready with out_ready so  |
// | back-to-back words flow at one slice per cycle.                          |
// | Ports: clk, rst_n (async active-low), clr (sync clear),                  |
// |        in_valid/in_ready/in_data[SLICE], out_valid/out_ready/            |
// |        out_data[WIDTH], fill_cnt (slices in current word).               |
// | Optional build macro: STREAM_UNPACK_RIGHT_EN (no slice reversal).        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module stream_unpack
  import stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 2,
  localparam int NSLICE = nslice(WIDTH, SLICE),
  localparam int CW = $clog2(NSLICE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SLICE-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    fill_cnt
);

  generate
    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
      $error("stream_unpack: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_n;
  logic             w_wr;
  logic [CW-1:0]    w_widx;
  logic             w_inc;
  logic             w_retire;
  logic             w_load1;
  logic [CW-1:0]    w_cnt;

  stream_slice_cnt #(
    .NSLICE (NSLICE)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (clr),
    .i_inc    (w_inc),
    .i_retire (w_retire),
    .i_load1  (w_load1),
    .o_cnt    (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    in_ready  = 1'b1;
    w_wr      = 1'b0;
    w_widx    = '0;
    w_inc     = 1'b0;
    w_retire  = 1'b0;
    w_load1   = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_wr   = 1'b1;
          w_widx = w_cnt;
          w_inc  = 1'b1;
          if (w_cnt == CW'(NSLICE - 1)) begin
            w_state_n = HOLD;
          end
        end
      end
      HOLD: begin
        // Bypass: a slice may enter only when the held word leaves.
        in_ready = out_ready;
        if (out_ready) begin
          w_retire = 1'b1;
          if (in_valid) begin
            // New slice becomes slice 0 of the next word; with one slice
            // per word that already completes it.
            w_wr      = 1'b1;
            w_widx    = '0;
            w_load1   = 1'b1;
            w_state_n = (NSLICE == 1) ? HOLD : FILL;
          end else begin
            w_state_n = FILL;
          end
        end
      end
      default: w_state_n = FILL;
    endcase
    // Clear drops any in-flight handshake on either side.
    if (clr) begin
      w_state_n = FILL;
      w_wr      = 1'b0;
      w_inc     = 1'b0;
      w_retire  = 1'b0;
      w_load1   = 1'b0;
    end
  end

  // Only the addressed slice changes; the rest of the word keeps its old
  // contents, which is safe because every slice is rewritten before valid.
  always_comb begin
    w_data_n = r_data;
    if (w_wr) begin
      for (int j = 0; j < NSLICE; j++) begin
        if (w_widx == CW'(j)) begin
          w_data_n[slice_lo(j, SLICE, WIDTH) +: SLICE] = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= w_data_n;
    end
  end

  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign fill_cnt  = w_cnt;

endmodule
`default_nettype wire
